xc_cmd_rx: RTL and testbench
============================

// Module: xc_cmd_rx
// PURPOSE
//  Host-to-device command path: deserialises the UART RX line (8N1 or 8E1) and decodes
//  each byte as {arg[7:4], cmd[3:0]}. Emits registered register-write strobes for the
//  per-line delay/clock blocks, plus LED, capture-enable and baud-select state.
//  Sits between the board RX pin and the correlator/spectrograph control logic in main.
// PARAMETERS
//  CLK_FREQUENCY  13300000  clki frequency in Hz
//  BAUD_RATE      57600     base baud rate; divider = CLK_FREQUENCY/(BAUD_RATE*16), truncated
//  NUM_LINES      8         number of input lines; wr_index range 0..NUM_LINES-1
// PORTS
//  clki       in   1                  clock
//  reset_n    in   1                  asynchronous, active-low reset
//  rx         in   1                  raw UART line, asynchronous to clki
//  wr_valid   out  1                  one-cycle strobe: wr_cmd/wr_index/wr_value valid
//  wr_cmd     out  4                  decoded command code
//  wr_index   out  $clog2(NUM_LINES)  currently selected line
//  wr_value   out  16                 {accumulator[11:0], arg}
//  leds       out  4                  LED flags
//  capture_en out  1                  capture enable
//  baud_sel   out  2                  active rate = BAUD_RATE << baud_sel
//  frame_err  out  1                  one-cycle strobe: bad stop/parity bit
//  cmd_err    out  1                  one-cycle strobe: unknown cmd or index out of range
// BEHAVIOUR
//  Reset: all outputs 0, accumulator 0, FSM IDLE, rx synchroniser flops preset to 1.
//  rx passes through a 2-flop synchroniser; a 16x tick is generated from (divider >> baud_sel).
//  FSM: IDLE -(sync rx=0)-> START; in START, rx must read 0 at tick 8, else back to IDLE
//  (glitch rejected). DATA: 8 bits, LSB first, each bit = 2-of-3 majority of ticks 7,8,9.
//  [PARITY] -> STOP: stop bit must be 1, else frame_err pulse and byte dropped -> IDLE.
//  A line held low after a bad stop bit waits for rx=1 before re-arming.
//  Latency: decoder outputs update 2 clki cycles after the stop-bit majority sample.
//  Commands (value = {acc, arg}, acc cleared after every non-EXTEND command):
//   0x0 CLEAR      acc, wr_index, leds, capture_en <= 0; baud_sel unchanged; wr_valid pulses
//   0x1 SET_INDEX  value < NUM_LINES: wr_index <= value; else cmd_err pulse, index held
//   0x2 SET_LEDS   leds <= value[3:0]
//   0x3 SET_BAUD   baud_sel <= value[1:0]; new divider takes effect at the next start bit
//   0x4 SET_DELAY, 0x5 SET_FREQ_DIV: write strobe only, targets wr_index
//   0x6 CAPTURE    capture_en <= value[0]
//   0xF EXTEND     acc <= {acc[7:0], arg}; no wr_valid; a 4th nibble drops the oldest one
//   0x7-0xE        cmd_err pulse, acc cleared, no wr_valid
//  wr_valid pulses for codes 0x0-0x6 (0x1 only when in range). wr_cmd/wr_value hold until the
//  next write. frame_err and cmd_err never coincide with wr_valid.
//  Reset asserted mid-byte: partial byte discarded; decoding restarts cleanly on the next start bit.
// CONFIGURATION
//  XC_CMD_PARITY_EN defined: 8E1 framing; a parity state samples one extra bit, a mismatch
//  pulses frame_err and drops the byte. Undefined: 8N1, no parity state, otherwise identical.
// STRUCTURE
//  Shared package xc_cmd_pkg: command code constants (CMD_CLEAR..CMD_EXTEND), accumulator
//  width (12), oversample factor (16), majority tick positions.
//  Sub-module xc_uart_rx_core: synchroniser, tick generator, framing FSM; outputs byte +
//  byte_valid + frame_err. Decoder and accumulator live in xc_cmd_rx.
// TESTING (CLK_FREQUENCY=13300000, BAUD_RATE=57600 -> divider 14)
//  1. Send 0x21 -> one wr_valid, wr_cmd=1, wr_index=2, wr_value=0x0002.
//  2. Send 0x1F,0x2F,0x34 -> a single wr_valid, wr_cmd=4, wr_value=0x0123; next 0x05 gives wr_value=0x0000.
//  3. Send 0x91 with NUM_LINES=8 -> cmd_err pulse, no wr_valid, wr_index unchanged.
//  4. Frame with stop bit = 0 -> frame_err pulse, no wr_valid/cmd_err; next good 0x16 -> capture_en=1.
//  5. rx low for 3 ticks only -> no state change; then 0x33 -> baud_sel=3; next byte received at 460800 baud.
//  6. Assert reset_n mid-DATA -> all outputs 0; the following 0x52 gives leds=5.
//  7. With XC_CMD_PARITY_EN: 0x21 with wrong parity -> frame_err; with correct parity -> accepted as in case 1.

Source files
------------

// File: rtl/xc_cmd_pkg.sv
// ---------------------------------------------------------------------------
// xc_cmd_pkg
// Shared definitions for the host-to-device command receiver:
//   - command codes carried in the low nibble of every received byte
//   - accumulator width used by EXTEND
//   - UART oversampling factor and the tick positions used for sampling
//   - receiver framing states
//   - a 2-of-3 majority helper
// Optional build macro: XC_CMD_PARITY_EN adds a parity framing state (8E1).
// ---------------------------------------------------------------------------
package xc_cmd_pkg;

    // Command codes, decoded from byte[3:0]
    localparam logic [3:0] CMD_CLEAR        = 4'h0;
    localparam logic [3:0] CMD_SET_INDEX    = 4'h1;
    localparam logic [3:0] CMD_SET_LEDS     = 4'h2;
    localparam logic [3:0] CMD_SET_BAUD     = 4'h3;
    localparam logic [3:0] CMD_SET_DELAY    = 4'h4;
    localparam logic [3:0] CMD_SET_FREQ_DIV = 4'h5;
    localparam logic [3:0] CMD_CAPTURE      = 4'h6;
    localparam logic [3:0] CMD_EXTEND       = 4'hF;

    // Accumulator holds three EXTEND nibbles; together with arg it forms a 16-bit value
    localparam int ACC_W = 12;

    // 16x oversampling; ticks inside one bit are numbered 0..15
    localparam int         OVERSAMPLE       = 16;
    localparam logic [3:0] TICK_MAJ_A       = 4'd7;
    localparam logic [3:0] TICK_MAJ_B       = 4'd8;
    localparam logic [3:0] TICK_MAJ_C       = 4'd9;
    localparam logic [3:0] TICK_START_CHECK = 4'd8;
    localparam logic [3:0] TICK_LAST        = 4'd15;

    // Receiver framing states
`ifdef XC_CMD_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;
`endif

    // 2-of-3 majority vote of the three mid-bit samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/xc_uart_rx_core.sv
// ---------------------------------------------------------------------------
// xc_uart_rx_core
// UART receiver: 2-flop synchroniser, 16x tick generator and framing FSM.
// Build macro XC_CMD_PARITY_EN selects 8E1 (even parity) instead of 8N1.
// Ports:
//   clki       in   clock
//   reset_n    in   asynchronous active-low reset
//   rx         in   raw UART line (asynchronous)
//   baud_sel   in   rate select; tick period = divider >> baud_sel, latched per frame
//   rx_byte    out  last good byte, valid with byte_valid
//   byte_valid out  one-cycle strobe, one cycle after the stop-bit decision
//   frame_err  out  one-cycle strobe for bad stop bit (or bad parity)
// ---------------------------------------------------------------------------
module xc_uart_rx_core
    import xc_cmd_pkg::*;
#(
    parameter int CLK_FREQUENCY = 13300000,
    parameter int BAUD_RATE     = 57600
) (
    input  logic       clki,
    input  logic       reset_n,
    input  logic       rx,
    input  logic [1:0] baud_sel,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int          DIVIDER  = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam logic [15:0] DIV_BASE = 16'(DIVIDER);

    rx_state_t   state_q;
    rx_state_t   state_d;
    logic        rx_meta;
    logic        rx_sync;
    logic [15:0] div_cnt;
    logic [15:0] div_eff;
    logic [15:0] div_sel;
    logic [15:0] div_next;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic [1:0]  samp_q;
    logic        counting;
    logic        tick;
    logic        maj;
    logic        at_decide;
    logic        at_bit_end;
    logic        stop_ok;
    logic        byte_done;
    logic        frm_bad;
`ifdef XC_CMD_PARITY_EN
    logic        par_err;
`endif

    // Fast rates shift the divider right; never let the tick period collapse to zero
    assign div_sel  = DIV_BASE >> baud_sel;
    assign div_next = (div_sel == 16'd0) ? 16'd1 : div_sel;

    assign counting   = (state_q != RX_IDLE) && (state_q != RX_WAIT_HIGH);
    assign tick       = counting && (div_cnt == div_eff - 16'd1);
    assign at_decide  = tick && (tick_cnt == TICK_MAJ_C);
    assign at_bit_end = tick && (tick_cnt == TICK_LAST);
    assign maj        = majority3(samp_q[1], samp_q[0], rx_sync);

`ifdef XC_CMD_PARITY_EN
    assign stop_ok = maj && !par_err;
`else
    assign stop_ok = maj;
`endif

    // Synchroniser flops idle high so reset never looks like a start bit
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Framing state register
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the stop bit is judged at the third majority tick so the
    // receiver re-arms before the stop bit ends. A bad stop waits for the line to rise.
    always_comb begin
        state_d   = state_q;
        byte_done = 1'b0;
        frm_bad   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick && (tick_cnt == TICK_START_CHECK) && rx_sync) begin
                    state_d = RX_IDLE;
                end else if (at_bit_end) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (at_bit_end && (bit_cnt == 3'd7)) begin
`ifdef XC_CMD_PARITY_EN
                    state_d = RX_PARITY;
`else
                    state_d = RX_STOP;
`endif
                end
            end
`ifdef XC_CMD_PARITY_EN
            RX_PARITY: begin
                if (at_bit_end) begin
                    state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (at_decide) begin
                    if (stop_ok) begin
                        state_d   = RX_IDLE;
                        byte_done = 1'b1;
                    end else begin
                        state_d = RX_WAIT_HIGH;
                        frm_bad = 1'b1;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Tick generation and bit assembly. The divider is latched when the start bit
    // is seen so a baud change only affects the following frame.
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            div_eff  <= 16'd1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            samp_q   <= '0;
            shift_q  <= '0;
        end else if (!counting) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            if ((state_q == RX_IDLE) && !rx_sync) begin
                div_eff <= div_next;
            end
        end else if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == TICK_MAJ_A) begin
                samp_q[1] <= rx_sync;
            end
            if (tick_cnt == TICK_MAJ_B) begin
                samp_q[0] <= rx_sync;
            end
            if ((state_q == RX_DATA) && (tick_cnt == TICK_MAJ_C)) begin
                shift_q <= {maj, shift_q[7:1]};
            end
            if ((state_q == RX_DATA) && (tick_cnt == TICK_LAST)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

`ifdef XC_CMD_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the eight data bits
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            par_err <= 1'b0;
        end else if (!counting) begin
            par_err <= 1'b0;
        end else if ((state_q == RX_PARITY) && at_decide) begin
            par_err <= (maj != ^shift_q);
        end
    end
`endif

    // Registered byte hand-off to the decoder
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= byte_done;
            frame_err  <= frm_bad;
            if (byte_done) begin
                rx_byte <= shift_q;
            end
        end
    end

endmodule

// File: rtl/xc_cmd_rx.sv
// ---------------------------------------------------------------------------
// xc_cmd_rx
// Host command path: UART receive plus byte decoder {arg[7:4], cmd[3:0]}.
// EXTEND bytes build a 12-bit accumulator that prefixes the next command's arg.
// Build macro XC_CMD_PARITY_EN selects 8E1 framing (default 8N1).
// Ports:
//   clki, reset_n  clock, asynchronous active-low reset
//   rx             raw UART line
//   wr_valid       one-cycle write strobe for wr_cmd/wr_index/wr_value
//   wr_cmd         decoded command code (held until next write)
//   wr_index       selected line
//   wr_value       {accumulator, arg} (held until next write)
//   leds           LED flags
//   capture_en     capture enable
//   baud_sel       active rate = BAUD_RATE << baud_sel
//   frame_err      one-cycle strobe: bad stop/parity bit
//   cmd_err        one-cycle strobe: unknown command or index out of range
// ---------------------------------------------------------------------------
module xc_cmd_rx
    import xc_cmd_pkg::*;
#(
    parameter int CLK_FREQUENCY = 13300000,
    parameter int BAUD_RATE     = 57600,
    parameter int NUM_LINES     = 8
) (
    input  logic                         clki,
    input  logic                         reset_n,
    input  logic                         rx,
    output logic                         wr_valid,
    output logic [3:0]                   wr_cmd,
    output logic [$clog2(NUM_LINES)-1:0] wr_index,
    output logic [15:0]                  wr_value,
    output logic [3:0]                   leds,
    output logic                         capture_en,
    output logic [1:0]                   baud_sel,
    output logic                         frame_err,
    output logic                         cmd_err
);

    localparam int IDX_W = $clog2(NUM_LINES);

    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             core_frame_err;
    logic [ACC_W-1:0] acc_q;
    logic [3:0]       cmd;
    logic [15:0]      value;
    logic             idx_ok;

    xc_uart_rx_core #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .BAUD_RATE     (BAUD_RATE)
    ) u_core (
        .clki       (clki),
        .reset_n    (reset_n),
        .rx         (rx),
        .baud_sel   (baud_sel),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (core_frame_err)
    );

    assign cmd    = rx_byte[3:0];
    assign value  = {acc_q, rx_byte[7:4]};
    assign idx_ok = 32'(value) < NUM_LINES;

    // Decoder. frame_err is delayed one cycle so it lines up with the write strobes.
    // Every command except EXTEND consumes the accumulator, including rejected ones.
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            wr_valid   <= 1'b0;
            wr_cmd     <= '0;
            wr_index   <= '0;
            wr_value   <= '0;
            leds       <= '0;
            capture_en <= 1'b0;
            baud_sel   <= '0;
            frame_err  <= 1'b0;
            cmd_err    <= 1'b0;
            acc_q      <= '0;
        end else begin
            wr_valid  <= 1'b0;
            cmd_err   <= 1'b0;
            frame_err <= core_frame_err;
            if (byte_valid) begin
                case (cmd)
                    CMD_EXTEND: begin
                        acc_q <= {acc_q[ACC_W-5:0], rx_byte[7:4]};
                    end
                    CMD_CLEAR: begin
                        acc_q      <= '0;
                        wr_index   <= '0;
                        leds       <= '0;
                        capture_en <= 1'b0;
                        wr_valid   <= 1'b1;
                        wr_cmd     <= cmd;
                        wr_value   <= value;
                    end
                    CMD_SET_INDEX: begin
                        acc_q <= '0;
                        if (idx_ok) begin
                            wr_index <= value[IDX_W-1:0];
                            wr_valid <= 1'b1;
                            wr_cmd   <= cmd;
                            wr_value <= value;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    CMD_SET_LEDS: begin
                        acc_q    <= '0;
                        leds     <= value[3:0];
                        wr_valid <= 1'b1;
                        wr_cmd   <= cmd;
                        wr_value <= value;
                    end
                    CMD_SET_BAUD: begin
                        acc_q    <= '0;
                        baud_sel <= value[1:0];
                        wr_valid <= 1'b1;
                        wr_cmd   <= cmd;
                        wr_value <= value;
                    end
                    CMD_SET_DELAY, CMD_SET_FREQ_DIV: begin
                        acc_q    <= '0;
                        wr_valid <= 1'b1;
                        wr_cmd   <= cmd;
                        wr_value <= value;
                    end
                    CMD_CAPTURE: begin
                        acc_q      <= '0;
                        capture_en <= value[0];
                        wr_valid   <= 1'b1;
                        wr_cmd     <= cmd;
                        wr_value   <= value;
                    end
                    default: begin
                        acc_q   <= '0;
                        cmd_err <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xc_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_xc_cmd_rx
// Scoreboard bench for xc_cmd_rx: each stimulus byte pushes its hand-computed
// expected event; a monitor pops and compares whenever a strobe appears.
// ---------------------------------------------------------------------------
module tb_xc_cmd_rx;

    localparam int CLK_FREQUENCY = 13300000;
    localparam int BAUD_RATE     = 57600;
    localparam int NUM_LINES     = 8;
    localparam int DIV           = CLK_FREQUENCY / (BAUD_RATE * 16);
`ifdef XC_CMD_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int K_NONE = -1;
    localparam int K_WR   = 0;
    localparam int K_CE   = 1;
    localparam int K_FE   = 2;

    typedef struct {
        int          kind;
        logic [3:0]  cmd;
        logic [2:0]  idx;
        logic [15:0] val;
        logic [3:0]  leds;
        logic        cap;
        logic [1:0]  baud;
    } exp_t;

    logic        clki;
    logic        reset_n;
    logic        rx;
    logic        wr_valid;
    logic [3:0]  wr_cmd;
    logic [2:0]  wr_index;
    logic [15:0] wr_value;
    logic [3:0]  leds;
    logic        capture_en;
    logic [1:0]  baud_sel;
    logic        frame_err;
    logic        cmd_err;

    int   total;
    int   bad;
    int   tb_baud;
    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_kind;

    xc_cmd_rx #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .BAUD_RATE     (BAUD_RATE),
        .NUM_LINES     (NUM_LINES)
    ) dut (
        .clki       (clki),
        .reset_n    (reset_n),
        .rx         (rx),
        .wr_valid   (wr_valid),
        .wr_cmd     (wr_cmd),
        .wr_index   (wr_index),
        .wr_value   (wr_value),
        .leds       (leds),
        .capture_en (capture_en),
        .baud_sel   (baud_sel),
        .frame_err  (frame_err),
        .cmd_err    (cmd_err)
    );

    // Free-running clock
    initial begin
        clki = 1'b0;
        forever #5 clki = ~clki;
    end

    // Global watchdog so the run always ends
    initial begin
        repeat (200000) @(posedge clki);
        $display("[TB] FAIL watchdog: got no finish within 200000 cycles, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic int bitCycles();
        int d;
        d = DIV >> tb_baud;
        if (d == 0) d = 1;
        return 16 * d;
    endfunction

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clki);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        int bc;
        bc = bitCycles();
        drive(1'b0, bc);
        for (int i = 0; i < 8; i++) drive(b[i], bc);
        if (PARITY_EN) drive((^b) ^ par_flip, bc);
        drive(stop_bit, bc);
        drive(1'b1, bc / 4);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clki);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending events required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int kind, input logic [3:0] cmd,
                                 input logic [2:0] idx, input logic [15:0] val, input logic [3:0] l,
                                 input logic cap, input logic [1:0] baud,
                                 input logic stop_bit, input logic par_flip);
        exp_t e;
        if (kind != K_NONE) begin
            e.kind = kind; e.cmd = cmd; e.idx = idx; e.val = val;
            e.leds = l; e.cap = cap; e.baud = baud;
            exp_q.push_back(e);
        end
        sendFrame(b, stop_bit, par_flip);
        waitDrain();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_valid"},   32'(wr_valid),   32'd0);
        checkOutput({tag, "_wr_cmd"},     32'(wr_cmd),     32'd0);
        checkOutput({tag, "_wr_index"},   32'(wr_index),   32'd0);
        checkOutput({tag, "_wr_value"},   32'(wr_value),   32'd0);
        checkOutput({tag, "_leds"},       32'(leds),       32'd0);
        checkOutput({tag, "_capture_en"}, 32'(capture_en), 32'd0);
        checkOutput({tag, "_baud_sel"},   32'(baud_sel),   32'd0);
        checkOutput({tag, "_frame_err"},  32'(frame_err),  32'd0);
        checkOutput({tag, "_cmd_err"},    32'(cmd_err),    32'd0);
    endtask

    // Monitor: whenever the DUT raises a strobe, pop the next expectation and compare
    always @(negedge clki) begin
        if (reset_n && (wr_valid || frame_err || cmd_err)) begin
            checkOutput("strobe_count", 32'(wr_valid) + 32'(frame_err) + 32'(cmd_err), 32'd1);
            mon_kind = wr_valid ? K_WR : (cmd_err ? K_CE : K_FE);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: got kind %0d required none", mon_kind);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("kind",       32'(mon_kind),   32'(mon_e.kind));
                checkOutput("wr_cmd",     32'(wr_cmd),     32'(mon_e.cmd));
                checkOutput("wr_index",   32'(wr_index),   32'(mon_e.idx));
                checkOutput("wr_value",   32'(wr_value),   32'(mon_e.val));
                checkOutput("leds",       32'(leds),       32'(mon_e.leds));
                checkOutput("capture_en", 32'(capture_en), 32'(mon_e.cap));
                checkOutput("baud_sel",   32'(baud_sel),   32'(mon_e.baud));
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        tb_baud = 0;
        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (5) @(negedge clki);
        checkAllZero("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clki);

        // SET_INDEX 2
        applyStimulus(8'h21, K_WR, 4'h1, 3'd2, 16'h0002, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        // EXTEND 1, EXTEND 2, SET_DELAY 3 -> 0x0123, then accumulator is empty again
        applyStimulus(8'h1F, K_NONE, 4'h0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h2F, K_NONE, 4'h0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h34, K_WR, 4'h4, 3'd2, 16'h0123, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h05, K_WR, 4'h5, 3'd2, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        // Four EXTEND nibbles: the oldest (1) is dropped
        applyStimulus(8'h1F, K_NONE, 4'h0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h2F, K_NONE, 4'h0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h3F, K_NONE, 4'h0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h4F, K_NONE, 4'h0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h55, K_WR, 4'h5, 3'd2, 16'h2345, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        // Index 9 out of range: cmd_err, index and write fields held
        applyStimulus(8'h91, K_CE, 4'h5, 3'd2, 16'h2345, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        // Unknown cmd after an EXTEND clears the accumulator
        applyStimulus(8'h1F, K_NONE, 4'h0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h0A, K_CE, 4'h5, 3'd2, 16'h2345, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h04, K_WR, 4'h4, 3'd2, 16'h0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        // Index boundary: 7 accepted, 8 rejected
        applyStimulus(8'h71, K_WR, 4'h1, 3'd7, 16'h0007, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'h81, K_CE, 4'h1, 3'd7, 16'h0007, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        // Bad stop bit drops the byte; the same byte framed correctly is accepted
        applyStimulus(8'h16, K_FE, 4'h1, 3'd7, 16'h0007, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(8'h16, K_WR, 4'h6, 3'd7, 16'h0001, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0);
        applyStimulus(8'hF2, K_WR, 4'h2, 3'd7, 16'h000F, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0);
        // CLEAR resets index, leds and capture
        applyStimulus(8'h40, K_WR, 4'h0, 3'd0, 16'h0004, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);

        // Glitch: three ticks low must not start a frame
        drive(1'b0, 3 * DIV);
        drive(1'b1, 2 * bitCycles());
        checkOutput("glitch_index", 32'(wr_index), 32'd0);
        checkOutput("glitch_cmd",   32'(wr_cmd),   32'd0);

        // SET_BAUD 3, then a byte at the eightfold rate
        applyStimulus(8'h33, K_WR, 4'h3, 3'd0, 16'h0003, 4'h0, 1'b0, 2'd3, 1'b1, 1'b0);
        tb_baud = 3;
        applyStimulus(8'hA2, K_WR, 4'h2, 3'd0, 16'h000A, 4'hA, 1'b0, 2'd3, 1'b1, 1'b0);

        // Reset in the middle of the data bits
        drive(1'b0, bitCycles());
        drive(1'b1, bitCycles());
        drive(1'b0, bitCycles());
        drive(1'b1, bitCycles() / 2);
        reset_n = 1'b0;
        repeat (3) @(negedge clki);
        checkAllZero("midreset");
        rx      = 1'b1;
        reset_n = 1'b1;
        tb_baud = 0;
        repeat (20) @(negedge clki);
        applyStimulus(8'h52, K_WR, 4'h2, 3'd0, 16'h0005, 4'h5, 1'b0, 2'd0, 1'b1, 1'b0);

`ifdef XC_CMD_PARITY_EN
        // Wrong parity is a framing error; correct parity decodes normally
        applyStimulus(8'h21, K_FE, 4'h2, 3'd0, 16'h0005, 4'h5, 1'b0, 2'd0, 1'b1, 1'b1);
        applyStimulus(8'h21, K_WR, 4'h1, 3'd2, 16'h0002, 4'h5, 1'b0, 2'd0, 1'b1, 1'b0);
`endif

        repeat (50) @(negedge clki);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
